// File: rtl/pc_counter.sv
// Registered up/down counter with parallel load, configurable step and
// overflow policy, plus boundary-event pulse and sticky overflow flag.
module pc_counter #(
  parameter int                 WIDTH     = 16,
  parameter int                 STEP      = 1,
  parameter bit                 SATURATE  = 1'b0,
  parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             inc,
  input  logic             dec,
  input  logic [WIDTH-1:0] in,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] out,
  output logic             wrap,
  output logic             ovf,
  output logic             at_max,
  output logic             at_min
);

  localparam logic [WIDTH:0]   STEP_X  = (WIDTH+1)'(STEP);
  localparam logic [WIDTH-1:0] MAX_VAL = '1;
  localparam logic [WIDTH-1:0] MIN_VAL = '0;

  typedef enum logic [1:0] {
    OP_HOLD = 2'd0,
    OP_LOAD = 2'd1,
    OP_INC  = 2'd2,
    OP_DEC  = 2'd3
  } op_e;

  op_e              op;
  logic [WIDTH:0]   sum_x;
  logic [WIDTH:0]   diff_x;
  logic             inc_evt;
  logic             dec_evt;
  logic [WIDTH-1:0] next_out;
  logic             next_evt;

  // Command decode: load beats inc/dec; inc and dec together cancel to hold.
  always_comb begin
    op = OP_HOLD;
    if (load)             op = OP_LOAD;
    else if (inc && !dec) op = OP_INC;
    else if (dec && !inc) op = OP_DEC;
  end

  // One extra bit exposes carry out of the add and borrow out of the subtract.
  assign sum_x   = {1'b0, out} + STEP_X;
  assign diff_x  = {1'b0, out} - STEP_X;
  assign inc_evt = sum_x[WIDTH];
  assign dec_evt = diff_x[WIDTH];

  always_comb begin
    next_out = out;
    next_evt = 1'b0;
    case (op)
      OP_LOAD: next_out = in;
      OP_INC: begin
        next_evt = inc_evt;
        if (inc_evt && SATURATE) next_out = MAX_VAL;
        else                     next_out = sum_x[WIDTH-1:0];
      end
      OP_DEC: begin
        next_evt = dec_evt;
        if (dec_evt && SATURATE) next_out = MIN_VAL;
        else                     next_out = diff_x[WIDTH-1:0];
      end
      default: next_out = out;
    endcase
  end

  // A boundary event on the same edge as clr_ovf leaves the flag set.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out  <= RESET_VAL;
      wrap <= 1'b0;
      ovf  <= 1'b0;
    end else begin
      out  <= next_out;
      wrap <= next_evt;
      if (next_evt)     ovf <= 1'b1;
      else if (clr_ovf) ovf <= 1'b0;
    end
  end

  assign at_max = (out == MAX_VAL);
  assign at_min = (out == MIN_VAL);

endmodule

// File: tb/tb_pc_counter.sv
// Bench for pc_counter: four parameterisations share one command stream and
// are checked every cycle against an arithmetic reference model.
module tb_pc_counter;

  localparam int NDUT = 4;
  localparam int P_W    [NDUT] = '{16, 16, 4, 4};
  localparam int P_STEP [NDUT] = '{1, 4, 3, 3};
  localparam int P_SAT  [NDUT] = '{0, 1, 0, 1};
  localparam int P_RV   [NDUT] = '{32'h0100, 32'h0100, 5, 0};

  logic        clk;
  logic        rst_n;
  logic        load;
  logic        inc;
  logic        dec;
  logic [15:0] in_v;
  logic        clr_ovf;

  logic [15:0] out0, out1;
  logic [3:0]  out2, out3;
  logic [15:0] d_out  [NDUT];
  logic        d_wrap [NDUT];
  logic        d_ovf  [NDUT];
  logic        d_max  [NDUT];
  logic        d_min  [NDUT];

  longint m_out  [NDUT];
  int     m_wrap [NDUT];
  int     m_ovf  [NDUT];

  int n_checks;
  int n_pass;

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  pc_counter #(.WIDTH(16), .STEP(1), .SATURATE(1'b0), .RESET_VAL(16'h0100)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .load(load), .inc(inc), .dec(dec), .in(in_v),
    .clr_ovf(clr_ovf), .out(out0), .wrap(d_wrap[0]), .ovf(d_ovf[0]),
    .at_max(d_max[0]), .at_min(d_min[0]));

  pc_counter #(.WIDTH(16), .STEP(4), .SATURATE(1'b1), .RESET_VAL(16'h0100)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .load(load), .inc(inc), .dec(dec), .in(in_v),
    .clr_ovf(clr_ovf), .out(out1), .wrap(d_wrap[1]), .ovf(d_ovf[1]),
    .at_max(d_max[1]), .at_min(d_min[1]));

  pc_counter #(.WIDTH(4), .STEP(3), .SATURATE(1'b0), .RESET_VAL(4'd5)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .load(load), .inc(inc), .dec(dec), .in(in_v[3:0]),
    .clr_ovf(clr_ovf), .out(out2), .wrap(d_wrap[2]), .ovf(d_ovf[2]),
    .at_max(d_max[2]), .at_min(d_min[2]));

  pc_counter #(.WIDTH(4), .STEP(3), .SATURATE(1'b1), .RESET_VAL(4'd0)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .load(load), .inc(inc), .dec(dec), .in(in_v[3:0]),
    .clr_ovf(clr_ovf), .out(out3), .wrap(d_wrap[3]), .ovf(d_ovf[3]),
    .at_max(d_max[3]), .at_min(d_min[3]));

  assign d_out[0] = out0;
  assign d_out[1] = out1;
  assign d_out[2] = {12'd0, out2};
  assign d_out[3] = {12'd0, out3};

  // scoreboard check
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  // Reference model: plain integer arithmetic on the command rules.
  task automatic model_step();
    for (int i = 0; i < NDUT; i++) begin
      longint maxv = (64'd1 << P_W[i]) - 1;
      longint nxt;
      int     evt;
      evt = 0;
      if (!rst_n) begin
        m_out[i]  = P_RV[i];
        m_wrap[i] = 0;
        m_ovf[i]  = 0;
      end else begin
        if (load) begin
          m_out[i] = longint'(in_v) % (maxv + 1);
        end else if (inc && !dec) begin
          nxt = m_out[i] + P_STEP[i];
          if (nxt > maxv) begin
            evt = 1;
            nxt = (P_SAT[i] != 0) ? maxv : nxt - (maxv + 1);
          end
          m_out[i] = nxt;
        end else if (dec && !inc) begin
          nxt = m_out[i] - P_STEP[i];
          if (nxt < 0) begin
            evt = 1;
            nxt = (P_SAT[i] != 0) ? 0 : nxt + (maxv + 1);
          end
          m_out[i] = nxt;
        end
        m_wrap[i] = evt;
        if (evt != 0)   m_ovf[i] = 1;
        else if (clr_ovf) m_ovf[i] = 0;
      end
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < NDUT; i++) begin
      longint maxv = (64'd1 << P_W[i]) - 1;
      check($sformatf("d%0d.out", i),    32'(d_out[i]),  32'(m_out[i]));
      check($sformatf("d%0d.wrap", i),   32'(d_wrap[i]), 32'(m_wrap[i]));
      check($sformatf("d%0d.ovf", i),    32'(d_ovf[i]),  32'(m_ovf[i]));
      check($sformatf("d%0d.at_max", i), 32'(d_max[i]),  32'(m_out[i] == maxv));
      check($sformatf("d%0d.at_min", i), 32'(d_min[i]),  32'(m_out[i] == 0));
    end
  endtask

  // driver: inputs change after the falling edge, DUT and model advance on the rising edge
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic drive(input logic r, input logic l, input logic i, input logic d,
                       input logic [15:0] v, input logic c);
    rst_n = r; load = l; inc = i; dec = d; in_v = v; clr_ovf = c;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    drive(1'b0, 1'b1, 1'b1, 1'b0, 16'h5555, 1'b0);

    // reset with load/inc asserted
    tick(); tick();
    check("rst.out", 32'(out0), 32'h0100);
    check("rst.wrap", 32'(d_wrap[0]), 32'd0);
    check("rst.ovf", 32'(d_ovf[0]), 32'd0);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 16'h0, 1'b0);
    tick();
    check("post_rst.inc", 32'(out0), 32'h0101);

    // wrap mode rollover
    drive(1'b1, 1'b1, 1'b0, 1'b0, 16'hFFFE, 1'b0);
    tick();
    drive(1'b1, 1'b0, 1'b1, 1'b0, 16'h0, 1'b0);
    tick();
    check("wrap.ffff", 32'(out0), 32'hFFFF);
    check("wrap.at_max", 32'(d_max[0]), 32'd1);
    check("wrap.nopulse", 32'(d_wrap[0]), 32'd0);
    tick();
    check("wrap.zero", 32'(out0), 32'h0000);
    check("wrap.pulse", 32'(d_wrap[0]), 32'd1);
    tick();
    check("wrap.one", 32'(out0), 32'h0001);
    check("wrap.pulse_end", 32'(d_wrap[0]), 32'd0);
    check("wrap.ovf_sticky", 32'(d_ovf[0]), 32'd1);

    // saturate mode, step 4
    drive(1'b1, 1'b1, 1'b0, 1'b0, 16'h0002, 1'b0);
    tick();
    drive(1'b1, 1'b0, 1'b0, 1'b1, 16'h0, 1'b0);
    tick();
    check("sat.dec1", 32'(out1), 32'h0000);
    check("sat.dec1.wrap", 32'(d_wrap[1]), 32'd1);
    tick();
    check("sat.dec2", 32'(out1), 32'h0000);
    check("sat.dec2.wrap", 32'(d_wrap[1]), 32'd1);
    check("sat.ovf", 32'(d_ovf[1]), 32'd1);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 16'hFFFD, 1'b0);
    tick();
    drive(1'b1, 1'b0, 1'b1, 1'b0, 16'h0, 1'b0);
    tick();
    check("sat.inc", 32'(out1), 32'hFFFF);
    check("sat.inc.wrap", 32'(d_wrap[1]), 32'd1);

    // priority: load over inc, inc+dec holds
    drive(1'b1, 1'b1, 1'b1, 1'b0, 16'h1234, 1'b0);
    tick();
    check("prio.load", 32'(out0), 32'h1234);
    check("prio.load.wrap", 32'(d_wrap[0]), 32'd0);
    drive(1'b1, 1'b0, 1'b1, 1'b1, 16'h0, 1'b0);
    tick();
    check("prio.hold", 32'(out0), 32'h1234);

    // ovf set/clear collision
    drive(1'b1, 1'b1, 1'b0, 1'b0, 16'hFFFF, 1'b0);
    tick();
    drive(1'b1, 1'b0, 1'b1, 1'b0, 16'h0, 1'b1);
    tick();
    check("coll.out", 32'(out0), 32'h0000);
    check("coll.ovf", 32'(d_ovf[0]), 32'd1);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
    tick();
    check("coll.clr", 32'(d_ovf[0]), 32'd0);

    // randomized command stream
    for (int n = 0; n < 1000; n++) begin
      drive(($urandom_range(0, 49) != 0), ($urandom_range(0, 7) == 0),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            16'($urandom), ($urandom_range(0, 9) == 0));
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
